// File: rtl/shift_counter_ctrl_pkg.sv
// Shared types and constants for the shift counter sequencer.
package shift_ctrl_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_PAUSE = 2'b11
  } op_t;

  // Sequencer states, also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // A ring counter seeded with all zeros never changes, so it is rejected.
  function automatic logic stuck_seed(input logic mode, input logic [3:0] seed);
    return (mode == MODE_RING) && (seed == 4'b0000);
  endfunction

endpackage

// File: rtl/shift_counter_ctrl_if.sv
// Command channel into the shift counter sequencer.
//
// Handshake: the master holds cmd_valid and the cmd_* fields stable until
// the cycle in which cmd_valid && cmd_ready is seen at a rising clk edge;
// that edge consumes exactly one command. cmd_ready never depends on
// cmd_valid (it is a decode of the registered state).
interface shift_counter_ctrl_if #(
  parameter int STEP_W = 8
);
  import shift_ctrl_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  op_t               cmd_op;
  logic              cmd_mode;
  logic [3:0]        cmd_seed;
  logic [STEP_W-1:0] cmd_steps;

  modport master (
    output cmd_valid, cmd_op, cmd_mode, cmd_seed, cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mode, cmd_seed, cmd_steps,
    output cmd_ready
  );

endinterface

// File: rtl/shift_counter_ctrl_step_prescaler.sv
// Step pacing divider. The count runs one cycle ahead of the step it
// announces: tick is raised in the cycle before the step so the parent can
// register it and still drive ctr_step on the exact step cycle. The parent
// asserts en when the following cycle is a RUN cycle, and clr on the cycle
// that enters LOAD.
module step_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // Free-running modulo-PRESCALE count that only advances while enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/shift_counter_ctrl.sv
// Sequencer for a 4-bit ring/Johnson shift counter: accepts commands,
// seeds the counter, paces and counts its shifts, and counts pattern wraps.
module shift_counter_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int STEP_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_counter_ctrl_if.slave  cmd,
  input  logic [3:0]           ctr_q,
  output logic                 ctr_mode,
  output logic                 ctr_lo,
  output logic [3:0]           ctr_load,
  output logic                 ctr_step,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [3:0]           wrap_cnt,
  output state_t               dbg_state
);

  state_t            state, state_n;
  logic [3:0]        seed_r;
  logic [STEP_W-1:0] steps_left;
  logic              wrap_chk;
  logic              tick;

  logic cmd_acc, start_acc, stop_acc, pause_acc;
  logic step_now, final_step, start_ok;

  assign cmd.cmd_ready = (state != ST_LOAD);
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

  assign cmd_acc   = cmd.cmd_valid && cmd.cmd_ready;
  assign start_acc = cmd_acc && (cmd.cmd_op == OP_START);
  assign stop_acc  = cmd_acc && (cmd.cmd_op == OP_STOP);
  assign pause_acc = cmd_acc && (cmd.cmd_op == OP_PAUSE);

  // A real shift happens only in RUN; the ctr_step of LOAD is the seed load.
  assign step_now   = ctr_step && (state == ST_RUN);
  assign final_step = step_now && (steps_left == STEP_W'(1));
  assign start_ok   = (cmd.cmd_steps != '0) && !stuck_seed(cmd.cmd_mode, cmd.cmd_seed);

  // Next-state decode, shared by the register block and the prescaler enable.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start_acc && start_ok) state_n = ST_LOAD;
      ST_LOAD:  state_n = ST_RUN;
      ST_RUN: begin
        if (final_step || stop_acc) state_n = ST_IDLE;
        else if (pause_acc)         state_n = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop_acc)       state_n = ST_IDLE;
        else if (pause_acc) state_n = ST_RUN;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  step_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (state_n == ST_RUN),
    .clr  ((state == ST_IDLE) && (state_n == ST_LOAD)),
    .tick (tick)
  );

  // State register, step/wrap counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ctr_mode   <= MODE_RING;
      ctr_lo     <= 1'b0;
      ctr_load   <= 4'b0000;
      ctr_step   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wrap_cnt   <= 4'd0;
      seed_r     <= 4'b0000;
      steps_left <= '0;
      wrap_chk   <= 1'b0;
    end else begin
      state    <= state_n;
      ctr_lo   <= 1'b0;
      ctr_step <= tick;
      done     <= 1'b0;
      err      <= 1'b0;
      wrap_chk <= step_now;

      if (step_now) steps_left <= steps_left - 1'b1;

      // The counter output reflects a step one cycle later.
      if (wrap_chk && (ctr_q == seed_r) && (wrap_cnt != 4'hF))
        wrap_cnt <= wrap_cnt + 4'd1;

      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            ctr_mode   <= cmd.cmd_mode;
            seed_r     <= cmd.cmd_seed;
            steps_left <= cmd.cmd_steps;
            wrap_cnt   <= 4'd0;
            if (cmd.cmd_steps == '0) begin
              done <= 1'b1;
            end else if (stuck_seed(cmd.cmd_mode, cmd.cmd_seed)) begin
              err <= 1'b1;
            end else begin
              ctr_lo   <= 1'b1;
              ctr_step <= 1'b1;
              ctr_load <= cmd.cmd_seed;
            end
          end else if (pause_acc) begin
            err <= 1'b1;
          end
        end
        ST_RUN: begin
          // STOP on the final step cancels the completion pulse.
          if (final_step && !stop_acc) done <= 1'b1;
          if (start_acc) err <= 1'b1;
        end
        ST_PAUSE: begin
          if (start_acc) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_counter_ctrl.sv
// Self-checking bench for shift_counter_ctrl with a behavioural shift counter.
module tb_shift_counter_ctrl;
  import shift_ctrl_pkg::*;

  localparam int STEP_W   = 8;
  localparam int PRESCALE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_counter_ctrl_if #(.STEP_W(STEP_W)) ifc ();
  shift_counter_ctrl_if #(.STEP_W(STEP_W)) ifc1 ();

  logic [3:0] ctr_q, ctr_load, wrap_cnt;
  logic       ctr_mode, ctr_lo, ctr_step, busy, done, err;
  state_t     dbg_state;

  logic [3:0] ctr_q_1, ctr_load_1, wrap_cnt_1;
  logic       ctr_mode_1, ctr_lo_1, ctr_step_1, busy_1, done_1, err_1;
  state_t     dbg_state_1;

  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  shift_counter_ctrl #(.PRESCALE(PRESCALE), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .cmd(ifc.slave), .ctr_q(ctr_q), .ctr_mode(ctr_mode),
    .ctr_lo(ctr_lo), .ctr_load(ctr_load), .ctr_step(ctr_step), .busy(busy),
    .done(done), .err(err), .wrap_cnt(wrap_cnt), .dbg_state(dbg_state)
  );

  shift_counter_ctrl #(.PRESCALE(1), .STEP_W(STEP_W)) dut1 (
    .clk(clk), .rst(rst), .cmd(ifc1.slave), .ctr_q(ctr_q_1), .ctr_mode(ctr_mode_1),
    .ctr_lo(ctr_lo_1), .ctr_load(ctr_load_1), .ctr_step(ctr_step_1), .busy(busy_1),
    .done(done_1), .err(err_1), .wrap_cnt(wrap_cnt_1), .dbg_state(dbg_state_1)
  );

  function automatic logic [3:0] next_pat(input logic mode, input logic [3:0] q);
    return (mode == MODE_JOHNSON) ? {q[2:0], ~q[3]} : {q[2:0], q[3]};
  endfunction

  // Behavioural 4-bit counters driven by the two sequencers.
  always_ff @(posedge clk) begin
    if (rst) ctr_q <= 4'b0000;
    else if (ctr_step) ctr_q <= ctr_lo ? ctr_load : next_pat(ctr_mode, ctr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) ctr_q_1 <= 4'b0000;
    else if (ctr_step_1) ctr_q_1 <= ctr_lo_1 ? ctr_load_1 : next_pat(ctr_mode_1, ctr_q_1);
  end

  // Driver: present one command and hold it until it is consumed.
  task automatic send_cmd(input op_t op, input logic mode, input logic [3:0] seed,
                          input logic [STEP_W-1:0] steps);
    int waited = 0;
    @(negedge clk);
    ifc.cmd_op = op; ifc.cmd_mode = mode; ifc.cmd_seed = seed; ifc.cmd_steps = steps;
    ifc.cmd_valid = 1'b1;
    while (!ifc.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (ifc.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", ifc.cmd_ready, waited);
    end
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.cmd_valid = 1'b1; ifc.cmd_op = OP_START; ifc.cmd_mode = MODE_JOHNSON;
    ifc.cmd_seed = 4'b0101; ifc.cmd_steps = 8'd3;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ctr_mode, ctr_lo, ctr_step, busy, done, err} !== 6'b0 || ctr_load !== 4'd0 ||
        wrap_cnt !== 4'd0 || ifc.cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: mode/lo/step/busy/done/err=%b load=%b wrap=%0d ready=%b state=%0d, required 0/0/0/0/0/0 0000 0 1 0",
               {ctr_mode, ctr_lo, ctr_step, busy, done, err}, ctr_load, wrap_cnt, ifc.cmd_ready, dbg_state);
    end
    ifc.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ctr_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b ctr_lo=%b, required 0 0", busy, ctr_lo);
    end
  endtask

  // One START run, scoreboarded on Q after every step, optional pause/resume.
  task automatic run_scored(input string name, input logic mode, input logic [3:0] seed,
                            input logic [STEP_W-1:0] steps, input logic [3:0] exp_wrap,
                            input int pause_after, input int pause_hold);
    logic [3:0] q, exp_v;
    int cyc = 0, last_step = 1, steps_seen = 0, lo_seen = 0, hold_left = 0;
    bit check_next = 0, done_seen = 0;
    exp_q.delete();
    q = seed;
    for (int i = 0; i < int'(steps); i++) begin
      q = next_pat(mode, q);
      exp_q.push_back(q);
    end
    send_cmd(OP_START, mode, seed, steps);
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ifc.cmd_valid) ifc.cmd_valid = 1'b0;
      if (check_next) begin
        check_next = 0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra_step: step %0d with empty queue, Q=%b", name, steps_seen, ctr_q);
        end else begin
          exp_v = exp_q.pop_front();
          if (ctr_q !== exp_v) begin
            n_fail++;
            $display("FAIL %s_q: step %0d Q=%b, required %b", name, steps_seen, ctr_q, exp_v);
          end
        end
      end
      if (ctr_lo) begin
        lo_seen++;
        n_checks++;
        if (ctr_load !== seed || ctr_step !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_load: ctr_load=%b ctr_step=%b, required %b 1", name, ctr_load, ctr_step, seed);
        end
      end
      if (hold_left > 0) begin
        n_checks++;
        if (ctr_step !== 1'b0 || dbg_state !== ST_PAUSE) begin
          n_fail++;
          $display("FAIL %s_pause_hold: ctr_step=%b state=%0d, required 0 %0d", name, ctr_step, dbg_state, ST_PAUSE);
        end
        hold_left--;
        if (hold_left == 0) begin
          ifc.cmd_op = OP_PAUSE; ifc.cmd_valid = 1'b1;
          last_step = cyc;
        end
      end else if (ctr_step && !ctr_lo) begin
        steps_seen++;
        n_checks++;
        if (cyc - last_step != PRESCALE) begin
          n_fail++;
          $display("FAIL %s_step_gap: step %0d gap %0d, required %0d", name, steps_seen, cyc - last_step, PRESCALE);
        end
        last_step = cyc;
        check_next = 1;
        if (steps_seen == pause_after) begin
          ifc.cmd_op = OP_PAUSE; ifc.cmd_valid = 1'b1;
          hold_left = pause_hold;
        end
      end
      if (done) begin
        done_seen = 1;
        n_checks++;
        if (steps_seen != int'(steps) || cyc != last_step + 1) begin
          n_fail++;
          $display("FAIL %s_done: steps=%0d at cycle %0d, required %0d at cycle %0d", name, steps_seen, cyc, steps, last_step + 1);
        end
      end
    end
    ifc.cmd_valid = 1'b0;
    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, cyc);
    end
    @(negedge clk);
    n_checks++;
    if (wrap_cnt !== exp_wrap || busy !== 1'b0 || lo_seen != 1 || exp_q.size() != 0 || ctr_mode !== mode) begin
      n_fail++;
      $display("FAIL %s_end: wrap=%0d busy=%b loads=%0d left=%0d mode=%b, required %0d 0 1 0 %b",
               name, wrap_cnt, busy, lo_seen, exp_q.size(), ctr_mode, exp_wrap, mode);
    end
  endtask

  task automatic test_illegal();
    send_cmd(OP_START, MODE_RING, 4'b0000, 8'd5);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || ctr_lo !== 1'b0 || done !== 1'b0 || wrap_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL stuck_seed: err=%b busy=%b lo=%b done=%b wrap=%0d, required 1 0 0 0 0", err, busy, ctr_lo, done, wrap_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_seed_after: err=%b busy=%b, required 0 0", err, busy);
    end
    send_cmd(OP_START, MODE_JOHNSON, 4'b0101, 8'd0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || ctr_lo !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || ctr_mode !== MODE_JOHNSON) begin
      n_fail++;
      $display("FAIL zero_steps: done=%b lo=%b busy=%b err=%b mode=%b, required 1 0 0 0 1", done, ctr_lo, busy, err, ctr_mode);
    end
    send_cmd(OP_PAUSE, MODE_RING, 4'b0001, 8'd1);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_idle: err=%b busy=%b, required 1 0", err, busy);
    end
    send_cmd(OP_STOP, MODE_RING, 4'b0001, 8'd1);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: err=%b done=%b busy=%b, required 0 0 0", err, done, busy);
    end
  endtask

  task automatic test_stop_final();
    int cyc = 0, steps_seen = 0, extra = 0;
    logic [3:0] exp_v;
    exp_q.delete();
    exp_q.push_back(4'b1000);
    send_cmd(OP_START, MODE_RING, 4'b0001, 8'd3);
    while (steps_seen < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ctr_step && !ctr_lo) steps_seen++;
    end
    n_checks++;
    if (steps_seen != 3) begin
      n_fail++;
      $display("FAIL stop_final_steps: steps=%0d, required 3", steps_seen);
    end
    ifc.cmd_op = OP_STOP; ifc.cmd_valid = 1'b1;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (ctr_q !== exp_v || done !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL stop_final: Q=%b done=%b busy=%b state=%0d, required %b 0 0 0", ctr_q, done, busy, dbg_state, exp_v);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || ctr_step) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL stop_final_quiet: %0d cycles with done/step, required 0", extra);
    end
  endtask

  task automatic test_start_while_run();
    int cyc = 0, steps_seen = 0;
    bit done_seen = 0;
    send_cmd(OP_START, MODE_RING, 4'b0010, 8'd3);
    while (steps_seen < 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ctr_step && !ctr_lo) steps_seen++;
    end
    send_cmd(OP_START, MODE_JOHNSON, 4'b1111, 8'd9);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b1 || ctr_mode !== MODE_RING || dbg_state !== ST_RUN) begin
      n_fail++;
      $display("FAIL start_in_run: err=%b busy=%b mode=%b state=%0d, required 1 1 0 %0d", err, busy, ctr_mode, dbg_state, ST_RUN);
    end
    cyc = 0;
    while (!done_seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ctr_step && !ctr_lo) steps_seen++;
      if (done) done_seen = 1;
    end
    n_checks++;
    if (!done_seen || steps_seen != 3 || ctr_q !== 4'b0001) begin
      n_fail++;
      $display("FAIL start_in_run_done: done=%b steps=%0d Q=%b, required 1 3 0001", done_seen, steps_seen, ctr_q);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int extra = 0;
    send_cmd(OP_START, MODE_JOHNSON, 4'b0001, 8'd20);
    repeat (9) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ctr_mode, ctr_lo, ctr_step, busy, done, err} !== 6'b0 || ctr_load !== 4'd0 ||
        wrap_cnt !== 4'd0 || ifc.cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL mid_run_reset: mode/lo/step/busy/done/err=%b load=%b wrap=%0d ready=%b state=%0d, required 000000 0000 0 1 0",
               {ctr_mode, ctr_lo, ctr_step, busy, done, err}, ctr_load, wrap_cnt, ifc.cmd_ready, dbg_state);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || ctr_step || busy) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL mid_run_quiet: %0d active cycles after reset, required 0", extra);
    end
  endtask

  task automatic test_prescale1();
    logic [3:0] q, exp_v;
    exp_q.delete();
    q = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      q = next_pat(MODE_RING, q);
      exp_q.push_back(q);
    end
    @(negedge clk);
    ifc1.cmd_op = OP_START; ifc1.cmd_mode = MODE_RING; ifc1.cmd_seed = 4'b0011;
    ifc1.cmd_steps = 8'd5; ifc1.cmd_valid = 1'b1;
    @(negedge clk);
    ifc1.cmd_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      n_checks++;
      if (ctr_lo_1 !== (c == 1) || ctr_step_1 !== (c <= 6) || done_1 !== (c == 7)) begin
        n_fail++;
        $display("FAIL p1_cycle%0d: lo=%b step=%b done=%b, required %b %b %b",
                 c, ctr_lo_1, ctr_step_1, done_1, (c == 1), (c <= 6), (c == 7));
      end
      if (c >= 3) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (ctr_q_1 !== exp_v) begin
          n_fail++;
          $display("FAIL p1_q%0d: Q=%b, required %b", c, ctr_q_1, exp_v);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    ifc.cmd_valid = 1'b0; ifc.cmd_op = OP_NOP; ifc.cmd_mode = MODE_RING;
    ifc.cmd_seed = 4'b0000; ifc.cmd_steps = '0;
    ifc1.cmd_valid = 1'b0; ifc1.cmd_op = OP_NOP; ifc1.cmd_mode = MODE_RING;
    ifc1.cmd_seed = 4'b0000; ifc1.cmd_steps = '0;
    test_reset();
    run_scored("ring4", MODE_RING, 4'b0001, 8'd4, 4'd1, -1, 0);
    run_scored("johnson8", MODE_JOHNSON, 4'b0000, 8'd8, 4'd1, -1, 0);
    test_illegal();
    run_scored("pause10", MODE_RING, 4'b1000, 8'd10, 4'd2, 2, 20);
    run_scored("wrap_sat", MODE_RING, 4'b0001, 8'd70, 4'd15, -1, 0);
    test_stop_final();
    test_start_while_run();
    test_reset_mid_run();
    test_prescale1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
